stopwatch_core: RTL and testbench
=================================

Name: stopwatch_core

Overview:
- Downstream consumer of the tick-pulse stage: masterToTimer emits a one-`clk` `clkOut` pulse per 1 Hz edge (run) or 2 Hz edge (adjust).
- This block holds the stopwatch value MM:SS in BCD and owns the run/pause/adjust state machine.
- Outputs feed the seven-segment scan/blink stage.
- All logic runs on the single system clock; the incoming tick is used only as an enable.

Parameters:
- MAX_MIN, 59, upper minute value before wrap to 00 (BCD-valid, 1..99).
- START_PAUSED, 1, state entered after reset: 1 = PAUSED, 0 = RUN.

Ports:
- clk  input  1  system clock, all flops rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle enable from the tick stage (1 Hz when ADJ=0, 2 Hz when ADJ=1).
- ADJ  input  1  level; 1 = adjust mode.
- SEL  input  1  level; in adjust, 0 = minutes field, 1 = seconds field.
- pause_pulse  input  1  one-cycle, already debounced, toggles run/pause.
- min_tens  output  4  BCD minutes tens.
- min_ones  output  4  BCD minutes ones.
- sec_tens  output  4  BCD seconds tens.
- sec_ones  output  4  BCD seconds ones.
- running  output  1  1 while in RUN.
- adj_field  output  2  00 = none; 01 = minutes selected; 10 = seconds selected (blink mask for display).
- rollover  output  1  one-cycle pulse on wrap MM:SS max -> 00:00 in RUN.

Behaviour:
- Reset (RESET=0, async): all digits 0.
  - State is PAUSED if START_PAUSED=1, else RUN.
  - running reflects that state; adj_field=00; rollover=0.
- All outputs are registered. A tick sampled at edge N is visible after edge N; no further pipeline.
- States: RUN, PAUSED, ADJUST.
- Transitions are evaluated each clk, in priority order:
  1. ADJ=1: go to ADJUST from any state.
  2. ADJUST with ADJ=0: go to PAUSED (never straight to RUN).
  3. RUN with pause_pulse: go to PAUSED.
  4. PAUSED with pause_pulse: go to RUN.
- pause_pulse is ignored in ADJUST.
- RUN, on tick:
  - sec_ones increments.
  - 9 -> 0 carries into sec_tens.
  - Seconds 59 -> 00 carries into minutes.
  - Minutes at MAX_MIN with carry wrap to 00 and assert rollover for exactly that cycle.
- PAUSED: tick ignored; value held.
- ADJUST, on tick:
  - SEL=0: minutes increment, MAX_MIN -> 00, seconds untouched, no rollover.
  - SEL=1: seconds increment, 59 -> 00, no carry into minutes.
- adj_field: 01 or 10 while in ADJUST per SEL; 00 otherwise.
- SEL changing mid-adjust takes effect on the next tick.
- Simultaneous tick and pause_pulse in RUN: the tick is counted (old state), then the state becomes PAUSED.
- Simultaneous tick and pause_pulse in PAUSED: the tick is not counted; RUN starts next cycle.
- Simultaneous ADJ rising and tick: the state becomes ADJUST, and this tick is treated under the old state's rule.
- Reset asserted mid-count: immediate clear regardless of clk. Release is synchronized by an internal 2-flop release synchronizer.
- Digit values never leave 0..9; wrap checks compare the full BCD pair, never the binary value.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding constants ST_RUN, ST_PAUSED, ST_ADJUST;
  - SEC_MAX_BCD = 8'h59;
  - adj_field codes.
- One sub-module, bcd_pair_counter:
  - two-digit BCD counter with inc enable, parameterised BCD limit, carry-out, synchronous clear.
  - Instantiated twice: seconds with limit 59, minutes with limit MAX_MIN.
  - Carry-out of seconds is gated into minutes only in RUN.

Test Plan:
- Reset with START_PAUSED=1, then pulse pause_pulse, then 75 ticks -> 01:15, running=1, rollover never asserted.
- Preload 59:58 via adjust, return to RUN (pause_pulse), 2 ticks -> 00:00, rollover high exactly one cycle coincident with 00:00.
- ADJ=1, SEL=1 at 00:58, 3 ticks -> 00:01, minutes unchanged; SEL=0, 61 ticks -> 01:01; adj_field tracks 10 then 01.
- RUN at 00:10, same-cycle tick and pause_pulse -> 00:11, running=0; further ticks hold 00:11.
- PAUSED at 00:11, same-cycle tick and pause_pulse -> 00:11, running=1 next cycle; next tick -> 00:12.
- Drive RESET low between clk edges mid-count at 12:34 -> digits 0 before the next edge; deassert -> state per START_PAUSED; first tick after 2 clks counts only if RUN.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_MIN  = 2'b01;
  localparam logic [1:0] ADJ_SEC  = 2'b10;

  // Converts a decimal parameter (0..99) into a packed two-digit BCD value.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    logic [7:0] result;
    result[7:4] = 4'((value / 10) % 10);
    result[3:0] = 4'(value % 10);
    return result;
  endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter that wraps at a BCD limit and flags the wrap as carry.
module bcd_pair_counter
  import stopwatch_pkg::*;
#(
  parameter logic [7:0] LIMIT = SEC_MAX_BCD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  logic at_limit;

  // The wrap test compares the full BCD pair, so digits can never pass 9.
  assign at_limit = ({tens, ones} == LIMIT);
  assign carry    = inc && at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_limit) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch MM:SS in BCD with run/pause/adjust control, advanced by a tick enable.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MIN      = 59,
  parameter bit          START_PAUSED = 1'b1
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic       pause_pulse,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic [1:0] adj_field,
  output logic       rollover
);

  localparam logic [7:0] MIN_MAX_BCD = to_bcd(MAX_MIN);
  localparam state_t     RESET_STATE = START_PAUSED ? ST_PAUSED : ST_RUN;

  logic [1:0] rst_sync;
  logic       rst_n;
  state_t     state;
  state_t     state_next;
  logic       sec_inc;
  logic       sec_carry;
  logic       min_inc;
  logic       min_carry;

  // NOTE: reset asserts asynchronously but releases two edges later, so no flop sees a mid-cycle release.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (ADJ) begin
      state_next = ST_ADJUST;
    end else if (state == ST_ADJUST) begin
      state_next = ST_PAUSED;
    end else if (pause_pulse) begin
      state_next = (state == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  // Increments follow the current state, so a tick coinciding with a transition uses the old rule.
  assign sec_inc = tick && ((state == ST_RUN) || ((state == ST_ADJUST) && SEL));
  assign min_inc = ((state == ST_RUN) && sec_carry) ||
                   (tick && (state == ST_ADJUST) && !SEL);

  bcd_pair_counter #(.LIMIT(SEC_MAX_BCD)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_pair_counter #(.LIMIT(MIN_MAX_BCD)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_field <= ADJ_NONE;
      rollover  <= 1'b0;
    end else begin
      adj_field <= (state_next == ST_ADJUST) ? (SEL ? ADJ_SEC : ADJ_MIN) : ADJ_NONE;
      rollover  <= (state == ST_RUN) && min_carry;
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a vector table plus multi-cycle corner sequences.
module tb_stopwatch_core;

  logic       clk;
  logic       RESET;
  logic       tick;
  logic       ADJ;
  logic       SEL;
  logic       pause_pulse;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running;
  logic [1:0] adj_field;
  logic       rollover;
  logic [15:0] value;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        tick;
    logic        adj;
    logic        sel;
    logic        pause;
    logic [15:0] exp_value;
    logic        exp_running;
    logic [1:0]  exp_adj;
    logic        exp_roll;
  } vec_t;

  vec_t vecs[12];

  stopwatch_core #(.MAX_MIN(59), .START_PAUSED(1'b1)) dut (
    .clk         (clk),
    .RESET       (RESET),
    .tick        (tick),
    .ADJ         (ADJ),
    .SEL         (SEL),
    .pause_pulse (pause_pulse),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .running     (running),
    .adj_field   (adj_field),
    .rollover    (rollover)
  );

  assign value = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit after it.
  task automatic apply(input logic t, input logic a, input logic s, input logic p);
    tick        = t;
    ADJ         = a;
    SEL         = s;
    pause_pulse = p;
    @(posedge clk);
    #1;
    tick        = 1'b0;
    pause_pulse = 1'b0;
  endtask

  initial begin
    logic seen_roll;

    RESET = 1'b0; tick = 1'b0; ADJ = 1'b0; SEL = 1'b0; pause_pulse = 1'b0;

    //        tick  adj   sel   pause  value     run   adj    roll
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0116, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0116, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0116, 1'b1, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0117, 1'b1, 2'b00, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0118, 1'b0, 2'b10, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0119, 1'b0, 2'b10, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0119, 1'b0, 2'b10, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0119, 1'b0, 2'b01, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0219, 1'b0, 2'b01, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0319, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0319, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0319, 1'b1, 2'b00, 1'b0};

    // Reset and release, then allow the release synchronizer to settle.
    repeat (3) @(posedge clk);
    #1 RESET = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_value", value, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd0);
    check("reset_adj_field", {14'd0, adj_field}, 16'd0);
    check("reset_rollover", {15'd0, rollover}, 16'd0);

    // Start running and count 75 seconds.
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    check("start_running", {15'd0, running}, 16'd1);
    seen_roll = 1'b0;
    for (int i = 0; i < 75; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0);
      if (rollover) seen_roll = 1'b1;
    end
    check("count75_value", value, 16'h0115);
    check("count75_running", {15'd0, running}, 16'd1);
    check("count75_no_rollover", {15'd0, seen_roll}, 16'd0);

    // Single-cycle vectors: simultaneous pulses, adjust entry/exit, SEL changes.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].tick, vecs[i].adj, vecs[i].sel, vecs[i].pause);
      check($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
      check($sformatf("vec%0d_running", i), {15'd0, running}, {15'd0, vecs[i].exp_running});
      check($sformatf("vec%0d_adj_field", i), {14'd0, adj_field}, {14'd0, vecs[i].exp_adj});
      check($sformatf("vec%0d_rollover", i), {15'd0, rollover}, {15'd0, vecs[i].exp_roll});
    end

    // Adjust minutes through the MAX_MIN wrap, then up to 59.
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    check("adj_min_field", {14'd0, adj_field}, 16'h0001);
    seen_roll = 1'b0;
    for (int i = 0; i < 57; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0);
      if (rollover) seen_roll = 1'b1;
    end
    check("adj_min_wrap_value", value, 16'h0019);
    check("adj_min_wrap_no_rollover", {15'd0, seen_roll}, 16'd0);
    for (int i = 0; i < 59; i++) apply(1'b1, 1'b1, 1'b0, 1'b0);
    check("adj_min_59", value, 16'h5919);

    // Adjust seconds through the 59 wrap without carrying into minutes.
    apply(1'b0, 1'b1, 1'b1, 1'b0);
    check("adj_sec_field", {14'd0, adj_field}, 16'h0002);
    for (int i = 0; i < 41; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("adj_sec_wrap_value", value, 16'h5900);
    for (int i = 0; i < 58; i++) apply(1'b1, 1'b1, 1'b1, 1'b0);
    check("preload_value", value, 16'h5958);

    // Leave adjust (lands in PAUSED), resume, then roll over 59:59 -> 00:00.
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    check("exit_adj_running", {15'd0, running}, 16'd0);
    check("exit_adj_field", {14'd0, adj_field}, 16'd0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    check("resume_running", {15'd0, running}, 16'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_roll_value", value, 16'h5959);
    check("pre_roll_rollover", {15'd0, rollover}, 16'd0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("roll_value", value, 16'h0000);
    check("roll_rollover", {15'd0, rollover}, 16'd1);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_roll_rollover", {15'd0, rollover}, 16'd0);

    // Reset asserted between edges mid-count clears immediately.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("precount_value", value, 16'h0005);
    #3 RESET = 1'b0;
    #1;
    check("async_reset_value", value, 16'h0000);
    check("async_reset_running", {15'd0, running}, 16'd0);
    @(posedge clk);
    #1 RESET = 1'b1;

    // During the two synchronizer edges the pause request must be ignored.
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    check("sync_ignores_pause", {15'd0, running}, 16'd0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("paused_tick_ignored", value, 16'h0000);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    check("post_reset_running", {15'd0, running}, 16'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_tick", value, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
